// File: rtl/sprite_compositor_if.sv
// Configuration write port for sprite_compositor: one strobe selects a
// layer and a field, and the data lands at the next rising clock edge.
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COORD_W    = 10
);
  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic               cfg_we;
  logic [LAYER_W-1:0] cfg_layer;
  logic [2:0]         cfg_field;
  logic [COORD_W-1:0] cfg_data;

  modport master (output cfg_we, cfg_layer, cfg_field, cfg_data);
  modport slave  (input  cfg_we, cfg_layer, cfg_field, cfg_data);
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor.
//   Stage 1: window hit test and sprite-relative addresses.
//   Stage 2: hit/blank delay so they line up with the returned pixels.
//   Stage 3: priority mux, colour-key transparency and per-frame collision tracking.
module sprite_compositor #(
  parameter int                   NUM_LAYERS = 4,
  parameter int                   COORD_W    = 10,
  parameter int                   COLOR_W    = 8,
  parameter logic [3*COLOR_W-1:0] KEY_RGB    = 24'hFE06FF
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic                            blank,
  input  logic [COORD_W-1:0]              scroll_x,
  sprite_compositor_if.slave              cfg,
  output logic [NUM_LAYERS*COORD_W-1:0]   local_x,
  output logic [NUM_LAYERS*COORD_W-1:0]   local_y,
  output logic [NUM_LAYERS-1:0]           layer_hit,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  output logic [COLOR_W-1:0]              Red,
  output logic [COLOR_W-1:0]              Green,
  output logic [COLOR_W-1:0]              Blue,
  output logic                            blank_out,
  output logic                            collision,
  output logic [NUM_LAYERS-1:0]           collision_mask
);

  localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int PIX_W   = 3 * COLOR_W;

  // Per-layer configuration registers
  logic [COORD_W-1:0]    pos_x_q  [NUM_LAYERS];
  logic [COORD_W-1:0]    pos_x_d  [NUM_LAYERS];
  logic [COORD_W-1:0]    pos_y_q  [NUM_LAYERS];
  logic [COORD_W-1:0]    pos_y_d  [NUM_LAYERS];
  logic [COORD_W-1:0]    size_x_q [NUM_LAYERS];
  logic [COORD_W-1:0]    size_x_d [NUM_LAYERS];
  logic [COORD_W-1:0]    size_y_q [NUM_LAYERS];
  logic [COORD_W-1:0]    size_y_d [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] en_q, en_d;
  logic [NUM_LAYERS-1:0] scroll_en_q, scroll_en_d;

  // Pipeline registers
  logic [NUM_LAYERS-1:0]         hit1_q, hit1_d;
  logic [NUM_LAYERS*COORD_W-1:0] local_x_q, local_x_d;
  logic [NUM_LAYERS*COORD_W-1:0] local_y_q, local_y_d;
  logic                          blank1_q, blank1_d;
  logic                          frame1_q, frame1_d;
  logic [NUM_LAYERS-1:0]         hit2_q, hit2_d;
  logic                          blank2_q, blank2_d;
  logic                          frame2_q, frame2_d;
  logic [PIX_W-1:0]              rgb_q, rgb_d;
  logic                          blank3_q, blank3_d;
  logic                          collision_q, collision_d;
  logic [NUM_LAYERS-1:0]         mask_q, mask_d;

  // Config write decode: only the addressed field of the addressed layer changes
  always_comb begin
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    size_x_d    = size_x_q;
    size_y_d    = size_y_q;
    en_d        = en_q;
    scroll_en_d = scroll_en_q;
    if (cfg.cfg_we) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (cfg.cfg_layer == LAYER_W'(i)) begin
          case (cfg.cfg_field)
            3'd0: pos_x_d[i]  = cfg.cfg_data;
            3'd1: pos_y_d[i]  = cfg.cfg_data;
            3'd2: size_x_d[i] = cfg.cfg_data;
            3'd3: size_y_d[i] = cfg.cfg_data;
            3'd4: begin
              en_d[i]        = cfg.cfg_data[0];
              scroll_en_d[i] = cfg.cfg_data[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Config register bank; reset wins over a simultaneous write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x_q     <= '{default: '0};
      pos_y_q     <= '{default: '0};
      size_x_q    <= '{default: '0};
      size_y_q    <= '{default: '0};
      en_q        <= '0;
      scroll_en_q <= '0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      size_x_q    <= size_x_d;
      size_y_q    <= size_y_d;
      en_q        <= en_d;
      scroll_en_q <= scroll_en_d;
    end
  end

  // Stage 1: window test carried one bit wider so sprites near the right edge never wrap
  always_comb begin
    logic [COORD_W:0] sx, x_lo, x_hi, y_lo, y_hi, dy, lx, ly;
    sx        = '0;
    x_lo      = '0;
    x_hi      = '0;
    y_lo      = '0;
    y_hi      = '0;
    dy        = {1'b0, DrawY};
    lx        = '0;
    ly        = '0;
    hit1_d    = '0;
    local_x_d = '0;
    local_y_d = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      sx   = {1'b0, DrawX} + (scroll_en_q[i] ? {1'b0, scroll_x} : '0);
      x_lo = {1'b0, pos_x_q[i]};
      x_hi = x_lo + {1'b0, size_x_q[i]};
      y_lo = {1'b0, pos_y_q[i]};
      y_hi = y_lo + {1'b0, size_y_q[i]};
      hit1_d[i] = en_q[i] && (sx >= x_lo) && (sx < x_hi) && (dy >= y_lo) && (dy < y_hi);
      lx = sx - x_lo;
      ly = dy - y_lo;
      local_x_d[i*COORD_W +: COORD_W] = lx[COORD_W-1:0];
      local_y_d[i*COORD_W +: COORD_W] = ly[COORD_W-1:0];
    end
    blank1_d = blank;
    frame1_d = (DrawX == '0) && (DrawY == '0);
  end

  // Stage 2 delay plus stage 3 compositing and collision accumulation
  always_comb begin
    logic [NUM_LAYERS-1:0] opaque;
    logic [PIX_W-1:0]      sel;
    int unsigned           n_opaque;
    logic                  coll_event;
    hit2_d   = hit1_q;
    blank2_d = blank1_q;
    frame2_d = frame1_q;
    opaque   = '0;
    sel      = bg_rgb;
    n_opaque = 0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = hit2_q[i] && (layer_rgb[i*PIX_W +: PIX_W] != KEY_RGB);
      if (opaque[i]) n_opaque = n_opaque + 1;
    end
    // Walk from the lowest-priority layer up so layer 0 is applied last
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (opaque[NUM_LAYERS-1-k]) sel = layer_rgb[(NUM_LAYERS-1-k)*PIX_W +: PIX_W];
    end
    coll_event  = blank2_q && (n_opaque >= 2);
    rgb_d       = blank2_q ? sel : '0;
    blank3_d    = blank2_q;
    collision_d = collision_q;
    mask_d      = mask_q;
    if (frame2_q) begin
      collision_d = coll_event;
      mask_d      = coll_event ? opaque : '0;
    end else if (coll_event) begin
      collision_d = 1'b1;
      mask_d      = mask_q | opaque;
    end
  end

  // Pipeline register stages
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit1_q      <= '0;
      local_x_q   <= '0;
      local_y_q   <= '0;
      blank1_q    <= 1'b0;
      frame1_q    <= 1'b0;
      hit2_q      <= '0;
      blank2_q    <= 1'b0;
      frame2_q    <= 1'b0;
      rgb_q       <= '0;
      blank3_q    <= 1'b0;
      collision_q <= 1'b0;
      mask_q      <= '0;
    end else begin
      hit1_q      <= hit1_d;
      local_x_q   <= local_x_d;
      local_y_q   <= local_y_d;
      blank1_q    <= blank1_d;
      frame1_q    <= frame1_d;
      hit2_q      <= hit2_d;
      blank2_q    <= blank2_d;
      frame2_q    <= frame2_d;
      rgb_q       <= rgb_d;
      blank3_q    <= blank3_d;
      collision_q <= collision_d;
      mask_q      <= mask_d;
    end
  end

  assign layer_hit      = hit1_q;
  assign local_x        = local_x_q;
  assign local_y        = local_y_q;
  assign Red            = rgb_q[PIX_W-1 -: COLOR_W];
  assign Green          = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign Blue           = rgb_q[COLOR_W-1:0];
  assign blank_out      = blank3_q;
  assign collision      = collision_q;
  assign collision_mask = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (4 layers, 10-bit coords, 8-bit colour).
module tb_sprite_compositor;

  localparam logic [23:0] KEY = 24'hFE06FF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, scroll_x;
  logic        blank;
  logic [39:0] local_x, local_y;
  logic [3:0]  layer_hit;
  logic [95:0] layer_rgb;
  logic [23:0] bg_rgb;
  logic [7:0]  Red, Green, Blue;
  logic        blank_out, collision;
  logic [3:0]  collision_mask;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_compositor_if #(.NUM_LAYERS(4), .COORD_W(10)) cfg_bus ();

  sprite_compositor #(
    .NUM_LAYERS(4), .COORD_W(10), .COLOR_W(8), .KEY_RGB(24'hFE06FF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x(scroll_x), .cfg(cfg_bus.slave), .local_x(local_x), .local_y(local_y),
    .layer_hit(layer_hit), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .Red(Red), .Green(Green), .Blue(Blue), .blank_out(blank_out),
    .collision(collision), .collision_mask(collision_mask)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] layer, input logic [2:0] field, input logic [9:0] data);
    cfg_bus.cfg_layer = layer;
    cfg_bus.cfg_field = field;
    cfg_bus.cfg_data  = data;
    cfg_bus.cfg_we    = 1'b1;
    tick();
    cfg_bus.cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h0) $display("FAIL reset_rgb got %h want 000000", {Red, Green, Blue}); else n_pass++;
    n_checks++; if (blank_out !== 1'b0) $display("FAIL reset_blank_out got %b want 0", blank_out); else n_pass++;
    n_checks++; if (layer_hit !== 4'b0) $display("FAIL reset_layer_hit got %b want 0000", layer_hit); else n_pass++;
    n_checks++; if (collision !== 1'b0 || collision_mask !== 4'b0) $display("FAIL reset_collision got %b/%b want 0/0000", collision, collision_mask); else n_pass++;
    n_checks++; if (local_x !== 40'h0 || local_y !== 40'h0) $display("FAIL reset_local got %h/%h want 0/0", local_x, local_y); else n_pass++;
    Reset = 1'b0;
  endtask

  task automatic test_basic_hit();
    bg_rgb    = 24'h202020;
    layer_rgb = {KEY, KEY, KEY, 24'h123456};
    cfg_write(0, 0, 100); cfg_write(0, 1, 50); cfg_write(0, 2, 16); cfg_write(0, 3, 16); cfg_write(0, 4, 1);
    DrawX = 100; DrawY = 50; blank = 1'b1;
    tick();
    n_checks++; if (layer_hit !== 4'b0001) $display("FAIL basic_hit got %b want 0001", layer_hit); else n_pass++;
    n_checks++; if (local_x[9:0] !== 10'd0 || local_y[9:0] !== 10'd0) $display("FAIL basic_local got %0d,%0d want 0,0", local_x[9:0], local_y[9:0]); else n_pass++;
    DrawX = 116;
    tick();
    n_checks++; if (layer_hit !== 4'b0000) $display("FAIL right_edge_miss got %b want 0000", layer_hit); else n_pass++;
    n_checks++; if ({Red, Green, Blue} !== 24'h0) $display("FAIL latency_early got %h want 000000", {Red, Green, Blue}); else n_pass++;
    tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h123456) $display("FAIL basic_rgb got %h want 123456", {Red, Green, Blue}); else n_pass++;
    n_checks++; if (blank_out !== 1'b1) $display("FAIL basic_blank_out got %b want 1", blank_out); else n_pass++;
    tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h202020) $display("FAIL miss_bg_rgb got %h want 202020", {Red, Green, Blue}); else n_pass++;
    DrawX = 115; DrawY = 65;
    tick();
    n_checks++; if (layer_hit !== 4'b0001 || local_x[9:0] !== 10'd15 || local_y[9:0] !== 10'd15)
      $display("FAIL corner_hit got %b %0d,%0d want 0001 15,15", layer_hit, local_x[9:0], local_y[9:0]); else n_pass++;
    DrawX = 107; DrawY = 66;
    tick();
    n_checks++; if (layer_hit !== 4'b0000) $display("FAIL bottom_edge_miss got %b want 0000", layer_hit); else n_pass++;
  endtask

  task automatic test_priority_collision();
    cfg_write(1, 0, 100); cfg_write(1, 1, 50); cfg_write(1, 2, 16); cfg_write(1, 3, 16); cfg_write(1, 4, 1);
    layer_rgb = {KEY, KEY, 24'hAA0000, KEY};
    DrawX = 104; DrawY = 52; blank = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++; if ({Red, Green, Blue} !== 24'hAA0000) $display("FAIL key_transparent got %h want AA0000", {Red, Green, Blue}); else n_pass++;
    n_checks++; if (collision !== 1'b0) $display("FAIL key_no_collision got %b want 0", collision); else n_pass++;
    layer_rgb = {KEY, KEY, 24'hAA0000, 24'h00FF00};
    tick(); tick(); tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h00FF00) $display("FAIL priority_rgb got %h want 00FF00", {Red, Green, Blue}); else n_pass++;
    n_checks++; if (collision !== 1'b1 || collision_mask !== 4'b0011) $display("FAIL overlap_collision got %b/%b want 1/0011", collision, collision_mask); else n_pass++;
  endtask

  task automatic test_frame_clear();
    DrawX = 0; DrawY = 0; blank = 1'b1;
    tick();
    DrawX = 5;
    tick();
    n_checks++; if (collision !== 1'b1) $display("FAIL frame_clear_early got %b want 1", collision); else n_pass++;
    tick();
    n_checks++; if (collision !== 1'b0 || collision_mask !== 4'b0) $display("FAIL frame_clear got %b/%b want 0/0000", collision, collision_mask); else n_pass++;
  endtask

  task automatic test_blanking();
    DrawX = 104; DrawY = 52; blank = 1'b0;
    tick(); tick(); tick(); tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h0 || blank_out !== 1'b0) $display("FAIL blank_forces_black got %h/%b want 000000/0", {Red, Green, Blue}, blank_out); else n_pass++;
    n_checks++; if (collision !== 1'b0 || collision_mask !== 4'b0) $display("FAIL blank_no_collision got %b/%b want 0/0000", collision, collision_mask); else n_pass++;
  endtask

  task automatic test_frame_set();
    blank = 1'b0;
    cfg_write(0, 0, 0); cfg_write(0, 1, 0); cfg_write(1, 0, 0); cfg_write(1, 1, 0);
    DrawX = 0; DrawY = 0; blank = 1'b1;
    tick();
    DrawX = 40; DrawY = 40;
    tick();
    n_checks++; if (collision !== 1'b0) $display("FAIL frame_set_early got %b want 0", collision); else n_pass++;
    tick();
    n_checks++; if (collision !== 1'b1 || collision_mask !== 4'b0011) $display("FAIL frame_set got %b/%b want 1/0011", collision, collision_mask); else n_pass++;
  endtask

  task automatic test_scroll();
    cfg_write(2, 0, 220); cfg_write(2, 1, 0); cfg_write(2, 2, 16); cfg_write(2, 3, 16); cfg_write(2, 4, 3);
    scroll_x = 30; DrawX = 190; DrawY = 5;
    tick();
    n_checks++; if (layer_hit[2] !== 1'b1 || local_x[29:20] !== 10'd0) $display("FAIL scroll_hit got %b/%0d want 1/0", layer_hit[2], local_x[29:20]); else n_pass++;
    DrawX = 205;
    tick();
    n_checks++; if (layer_hit[2] !== 1'b1 || local_x[29:20] !== 10'd15) $display("FAIL scroll_edge got %b/%0d want 1/15", layer_hit[2], local_x[29:20]); else n_pass++;
    DrawX = 206;
    tick();
    n_checks++; if (layer_hit[2] !== 1'b0) $display("FAIL scroll_past_edge got %b want 0", layer_hit[2]); else n_pass++;
    DrawX = 190;
    cfg_write(2, 4, 1);
    tick();
    n_checks++; if (layer_hit[2] !== 1'b0) $display("FAIL scroll_disabled got %b want 0", layer_hit[2]); else n_pass++;
  endtask

  task automatic test_no_wrap();
    scroll_x = 0;
    cfg_write(3, 0, 1020); cfg_write(3, 1, 0); cfg_write(3, 2, 10); cfg_write(3, 3, 16); cfg_write(3, 4, 1);
    DrawX = 1023; DrawY = 5;
    tick();
    n_checks++; if (layer_hit[3] !== 1'b1 || local_x[39:30] !== 10'd3) $display("FAIL nowrap_hit got %b/%0d want 1/3", layer_hit[3], local_x[39:30]); else n_pass++;
    DrawX = 3;
    tick();
    n_checks++; if (layer_hit[3] !== 1'b0) $display("FAIL nowrap_low_miss got %b want 0", layer_hit[3]); else n_pass++;
    cfg_write(3, 4, 3);
    scroll_x = 1000; DrawX = 25;
    tick();
    n_checks++; if (layer_hit[3] !== 1'b1 || local_x[39:30] !== 10'd5) $display("FAIL nowrap_scroll got %b/%0d want 1/5", layer_hit[3], local_x[39:30]); else n_pass++;
    DrawX = 30;
    tick();
    n_checks++; if (layer_hit[3] !== 1'b0) $display("FAIL nowrap_scroll_edge got %b want 0", layer_hit[3]); else n_pass++;
    DrawX = 25;
    cfg_write(3, 2, 0);
    tick();
    n_checks++; if (layer_hit[3] !== 1'b0) $display("FAIL zero_size got %b want 0", layer_hit[3]); else n_pass++;
    scroll_x = 0;
  endtask

  task automatic test_reset_mid_frame();
    DrawX = 2; DrawY = 2; blank = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h00FF00 || collision !== 1'b1) $display("FAIL pre_reset got %h/%b want 00FF00/1", {Red, Green, Blue}, collision); else n_pass++;
    Reset = 1'b1;
    cfg_bus.cfg_layer = 0; cfg_bus.cfg_field = 3'd2; cfg_bus.cfg_data = 10'd16; cfg_bus.cfg_we = 1'b1;
    tick();
    cfg_bus.cfg_we = 1'b0;
    n_checks++; if ({Red, Green, Blue} !== 24'h0 || blank_out !== 1'b0 || layer_hit !== 4'b0) $display("FAIL mid_reset_out got %h/%b/%b want 000000/0/0000", {Red, Green, Blue}, blank_out, layer_hit); else n_pass++;
    n_checks++; if (collision !== 1'b0 || collision_mask !== 4'b0) $display("FAIL mid_reset_coll got %b/%b want 0/0000", collision, collision_mask); else n_pass++;
    Reset = 1'b0;
    tick();
    n_checks++; if (layer_hit !== 4'b0) $display("FAIL cfg_cleared got %b want 0000", layer_hit); else n_pass++;
    tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h0 || blank_out !== 1'b0) $display("FAIL flush_hold got %h/%b want 000000/0", {Red, Green, Blue}, blank_out); else n_pass++;
    tick();
    n_checks++; if ({Red, Green, Blue} !== 24'h202020 || blank_out !== 1'b1) $display("FAIL flush_release got %h/%b want 202020/1", {Red, Green, Blue}, blank_out); else n_pass++;
    cfg_write(0, 3, 16); cfg_write(0, 4, 1);
    tick();
    n_checks++; if (layer_hit[0] !== 1'b0) $display("FAIL reset_over_cfg got %b want 0", layer_hit[0]); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1; DrawX = 0; DrawY = 0; blank = 1'b0; scroll_x = 0;
    layer_rgb = {4{KEY}}; bg_rgb = 24'h0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_layer = 0; cfg_bus.cfg_field = 0; cfg_bus.cfg_data = 0;
    test_reset();
    test_basic_hit();
    test_priority_collision();
    test_frame_clear();
    test_blanking();
    test_frame_set();
    test_scroll();
    test_no_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule
